data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, consecutive port-0 grants against a pending port-1 request before port 1 is forced (range 1..15).
REQ-002 SHALL have ports, in this order:
- clk_i  input  1  single clock, all state on rising edge.
- reset_i  input  1  reset, asynchronous and active-high.
- p0_req  input  1  port 0 (pipeline LSU) access request.
- p0_we  input  1  port 0 write enable.
- p0_width  input  2  port 0 width (00 word, 10 halfword, 01 byte).
- p0_addr  input  32  port 0 byte address.
- p0_wdata  input  32  port 0 write data.
- p0_gnt  output  1  port 0 granted this cycle.
- p0_rvalid  output  1  port 0 response valid.
- p0_rdata  output  32  port 0 read data.
- p0_err  output  1  port 0 misaligned-access error.
- p1_req, p1_we, p1_width, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same as port 0, for port 1 (debug/loader).
- mem_we  output  1  to data memory WE.
- mem_width_src  output  2  to data memory width_src.
- mem_a  output  32  to data memory A.
- mem_wd  output  32  to data memory WD.
- mem_rd  input  32  from data memory RD (combinational read of mem_a).

Function
REQ-003 SHALL grant at most one port per cycle; pN_gnt is combinational from pN_req and arbiter state in the same cycle.
REQ-004 SHALL grant port 0 when only p0_req is high and port 1 when only p1_req is high; no request gives no grant, mem_we=0.
REQ-005 SHALL, when both request, grant port 0 unless the starve counter equals STARVE_LIMIT, in which case port 1 is granted.
REQ-006 SHALL increment a 4-bit starve counter on each cycle port 0 is granted while p1_req is high, and clear it on any port-1 grant or any cycle p1_req is low.
REQ-007 SHALL drive mem_a, mem_width_src, mem_wd from the granted port; with no grant they hold zero.
REQ-008 SHALL flag an access misaligned when width=00 and addr[1:0]!=0, or width=10 and addr[0]!=0; width=01 is never misaligned; width=11 is treated as word.
REQ-009 SHALL drive mem_we = granted port's we AND NOT misaligned; a misaligned write never reaches memory.
REQ-010 SHALL register the response: in cycle N+1 after a grant in cycle N, pN_rvalid=1 for exactly one cycle, pN_rdata = mem_rd sampled at end of cycle N (0 if misaligned), pN_err = misaligned flag.
REQ-011 SHALL assert rvalid for writes as well as reads (write acknowledge); pN_rdata for a write is the pre-write memory content at mem_a.
REQ-012 SHALL support back-to-back grants to the same or alternating ports every cycle with no bubble; response ordering equals grant ordering.
REQ-013 SHALL never assert both pX_rvalid outputs in the same cycle.
REQ-014 SHALL not depend on a requester holding req after grant; a request deasserted before being granted is dropped with no response.

Reset
REQ-015 SHALL, while reset_i is high, force p0_gnt=p1_gnt=0, mem_we=0, mem_a=mem_wd=0, mem_width_src=00, regardless of requests.
REQ-016 SHALL asynchronously clear the starve counter, both rvalid, both err and both rdata registers to 0.
REQ-017 SHALL discard any response pending when reset asserts; the first grant after release gets a normal N+1 response.

Verification
REQ-018 Solo read: p0 word-write 0xDEADBEEF at 0x10, then p0 read 0x10 -> p0_gnt same cycle, next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF, p0_err=0.
REQ-019 Contention: both req high continuously, STARVE_LIMIT=4 -> grant pattern P0,P0,P0,P0,P1 repeating; never two grants in one cycle.
REQ-020 Misalignment: p1 word write 0x12345678 at 0x22 -> mem_we=0, next cycle p1_err=1, p1_rdata=0; word read at 0x20 shows prior content unchanged.
REQ-021 Widths: p1 byte writes 0x11..0x44 to 0x40..0x43, p0 halfword read 0x42 -> p0_rdata[15:0]=0x4433; halfword at 0x41 -> p0_err=1.
REQ-022 Reset mid-operation: grant p0 read, assert reset_i before next edge -> p0_rvalid stays 0, counter 0; after release p1 request granted and answered one cycle later.
REQ-023 Withdrawn request: p1_req pulsed one cycle during p0-priority cycle -> no p1_gnt, no p1_rvalid, starve counter returns to 0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter in front of a single-ported data memory.
// Port 0 (pipeline LSU) has priority; port 1 (debug/loader) is forced in after
// STARVE_LIMIT consecutive port-0 wins against it. Each grant produces a
// registered one-cycle response in the following cycle.
module data_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [1:0]  p0_width,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [1:0]  p1_width,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_we,
    output logic [1:0]  mem_width_src,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Width encoding: 00 word, 10 halfword, 01 byte; 11 behaves as word.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lsb);
        logic r;
        case (width)
            2'b01:   r = 1'b0;
            2'b10:   r = addr_lsb[0];
            default: r = (addr_lsb != 2'b00);
        endcase
        return r;
    endfunction

    logic [3:0]  starve_q, starve_d;
    logic        gnt0_s, gnt1_s;
    logic        sel_we_s, mis_s;
    logic [1:0]  sel_width_s;
    logic [31:0] sel_addr_s, sel_wdata_s, rsp_data_s;
    logic        p0_rvalid_q, p0_err_q, p1_rvalid_q, p1_err_q;
    logic [31:0] p0_rdata_q, p1_rdata_q;

    // Grant decision: port 1 wins when alone or when port 0 has starved it long enough.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset_i) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (p1_req && (!p0_req || (starve_q == LIMIT))) begin
            gnt1_s = 1'b1;
        end else if (p0_req) begin
            gnt0_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Steer the granted port onto the memory bus; idle bus is all zeros.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_width_s = 2'b00;
        sel_addr_s  = 32'h0000_0000;
        sel_wdata_s = 32'h0000_0000;
        if (gnt1_s) begin
            sel_we_s    = p1_we;
            sel_width_s = p1_width;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
        end else if (gnt0_s) begin
            sel_we_s    = p0_we;
            sel_width_s = p0_width;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
        end else begin
            sel_we_s    = 1'b0;
            sel_width_s = 2'b00;
            sel_addr_s  = 32'h0000_0000;
            sel_wdata_s = 32'h0000_0000;
        end
        mis_s      = is_misaligned(sel_width_s, sel_addr_s[1:0]);
        rsp_data_s = mis_s ? 32'h0000_0000 : mem_rd;
    end

    // Starve counter next state: counts port-0 wins over a waiting port 1.
    always_comb begin
        starve_d = 4'd0;
        if (gnt0_s && p1_req) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = 4'd0;
        end
    end

    // Starve counter register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Response registers: one-cycle rvalid with captured read data and error flag.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            p0_rvalid_q <= 1'b0;
            p0_err_q    <= 1'b0;
            p0_rdata_q  <= 32'h0000_0000;
            p1_rvalid_q <= 1'b0;
            p1_err_q    <= 1'b0;
            p1_rdata_q  <= 32'h0000_0000;
        end else begin
            p0_rvalid_q <= gnt0_s;
            p0_err_q    <= gnt0_s & mis_s;
            p1_rvalid_q <= gnt1_s;
            p1_err_q    <= gnt1_s & mis_s;
            if (gnt0_s) begin
                p0_rdata_q <= rsp_data_s;
            end
            if (gnt1_s) begin
                p1_rdata_q <= rsp_data_s;
            end
        end
    end

    assign p0_gnt        = gnt0_s;
    assign p1_gnt        = gnt1_s;
    assign mem_we        = sel_we_s & ~mis_s;
    assign mem_width_src = sel_width_s;
    assign mem_a         = sel_addr_s;
    assign mem_wd        = sel_wdata_s;
    assign p0_rvalid     = p0_rvalid_q;
    assign p0_rdata      = p0_rdata_q;
    assign p0_err        = p0_err_q;
    assign p1_rvalid     = p1_rvalid_q;
    assign p1_rdata      = p1_rdata_q;
    assign p1_err        = p1_err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a byte-addressed
// little-endian memory model (combinational read, write on rising edge).
module tb_data_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [1:0]  p0_width, p1_width;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [1:0]  mem_width_src;
    logic [31:0] mem_a, mem_wd, mem_rd;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:255];
    logic [7:0] ma;
    assign ma = mem_a[7:0];

    always #5 clk_i = ~clk_i;

    data_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .p0_req(p0_req), .p0_we(p0_we), .p0_width(p0_width), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_width(p1_width), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_width_src(mem_width_src), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Memory model read path.
    always_comb begin
        case (mem_width_src)
            2'b01:   mem_rd = {24'h000000, mem[ma]};
            2'b10:   mem_rd = {16'h0000, mem[ma + 8'd1], mem[ma]};
            default: mem_rd = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
        endcase
    end

    // Memory model write path.
    always @(posedge clk_i) begin
        if (mem_we) begin
            mem[ma] <= mem_wd[7:0];
            if (mem_width_src != 2'b01) mem[ma + 8'd1] <= mem_wd[15:8];
            if (mem_width_src != 2'b01 && mem_width_src != 2'b10) begin
                mem[ma + 8'd2] <= mem_wd[23:16];
                mem[ma + 8'd3] <= mem_wd[31:24];
            end
        end
    end

    task automatic set_p0(input logic req, input logic we, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        p0_req = req; p0_we = we; p0_width = w; p0_addr = a; p0_wdata = d;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        p1_req = req; p1_we = we; p1_width = w; p1_addr = a; p1_wdata = d;
    endtask

    task automatic idle();
        set_p0(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        set_p1(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        set_p0(1'b1, 1'b1, 2'b00, 32'h10, 32'hFFFF_FFFF);
        set_p1(1'b1, 1'b1, 2'b00, 32'h14, 32'hFFFF_FFFF);
        @(posedge clk_i); #1;
        n_checks++; if (p0_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_p0_gnt: got %b want 0", p0_gnt); end
        n_checks++; if (p1_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_p1_gnt: got %b want 0", p1_gnt); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        n_checks++; if ({mem_a, mem_wd, mem_width_src} !== 66'h0) begin n_fail++; $display("FAIL rst_bus: got a=%h wd=%h w=%b want 0", mem_a, mem_wd, mem_width_src); end
        n_checks++; if ({p0_rvalid, p1_rvalid, p0_err, p1_err} !== 4'b0000) begin n_fail++; $display("FAIL rst_rsp_flags: got %b want 0000", {p0_rvalid, p1_rvalid, p0_err, p1_err}); end
        n_checks++; if ({p0_rdata, p1_rdata} !== 64'h0) begin n_fail++; $display("FAIL rst_rdata: got %h %h want 0", p0_rdata, p1_rdata); end
        @(negedge clk_i);
        reset_i = 1'b0;
        idle();
    endtask

    task automatic test_solo();
        // p0 word write DEADBEEF at 0x10
        set_p0(1'b1, 1'b1, 2'b00, 32'h10, 32'hDEAD_BEEF); #1;
        n_checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin n_fail++; $display("FAIL solo_wr_gnt: got %b%b want 10", p0_gnt, p1_gnt); end
        n_checks++; if (mem_we !== 1'b1 || mem_a !== 32'h10 || mem_wd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL solo_wr_bus: got we=%b a=%h wd=%h want 1 10 deadbeef", mem_we, mem_a, mem_wd); end
        @(posedge clk_i); #1;
        n_checks++; if (p0_rvalid !== 1'b1 || p0_err !== 1'b0 || p1_rvalid !== 1'b0) begin n_fail++; $display("FAIL solo_wr_ack: got rv=%b err=%b rv1=%b want 1 0 0", p0_rvalid, p0_err, p1_rvalid); end
        n_checks++; if (p0_rdata !== 32'h0) begin n_fail++; $display("FAIL solo_wr_prewrite: got %h want 0", p0_rdata); end
        // p0 word read 0x10
        @(negedge clk_i);
        set_p0(1'b1, 1'b0, 2'b00, 32'h10, 32'h0); #1;
        n_checks++; if (p0_gnt !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL solo_rd_gnt: got gnt=%b we=%b want 1 0", p0_gnt, mem_we); end
        @(posedge clk_i); #1;
        n_checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hDEAD_BEEF || p0_err !== 1'b0) begin n_fail++; $display("FAIL solo_rd_rsp: got rv=%b d=%h err=%b want 1 deadbeef 0", p0_rvalid, p0_rdata, p0_err); end
        // no request: no grant, rvalid drops after one cycle
        @(negedge clk_i);
        idle(); #1;
        n_checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || mem_we !== 1'b0 || mem_a !== 32'h0) begin n_fail++; $display("FAIL idle_bus: got g=%b%b we=%b a=%h want 00 0 0", p0_gnt, p1_gnt, mem_we, mem_a); end
        @(posedge clk_i); #1;
        n_checks++; if (p0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_one_cycle: got %b want 0", p0_rvalid); end
        // p1 alone gets the bus
        @(negedge clk_i);
        set_p1(1'b1, 1'b0, 2'b00, 32'h10, 32'h0); #1;
        n_checks++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin n_fail++; $display("FAIL solo_p1_gnt: got %b%b want 01", p0_gnt, p1_gnt); end
        @(posedge clk_i); #1;
        n_checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hDEAD_BEEF || p0_rvalid !== 1'b0) begin n_fail++; $display("FAIL solo_p1_rsp: got rv=%b d=%h rv0=%b want 1 deadbeef 0", p1_rvalid, p1_rdata, p0_rvalid); end
        @(negedge clk_i);
        idle();
    endtask

    // Both ports request for n cycles; expected pattern P0 x4, P1, repeat.
    task automatic test_contention(input int n, input string tag);
        logic prev_g1;
        prev_g1 = 1'b0;
        set_p0(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
        set_p1(1'b1, 1'b0, 2'b01, 32'h11, 32'h0);
        for (int i = 0; i < n; i++) begin
            logic g1;
            g1 = ((i % 5) == 4);
            #1;
            n_checks++; if (p0_gnt !== ~g1 || p1_gnt !== g1) begin n_fail++; $display("FAIL %s_gnt[%0d]: got %b%b want %b%b", tag, i, p0_gnt, p1_gnt, ~g1, g1); end
            if (i > 0) begin
                n_checks++; if (p0_rvalid !== ~prev_g1 || p1_rvalid !== prev_g1) begin n_fail++; $display("FAIL %s_rv[%0d]: got %b%b want %b%b", tag, i, p0_rvalid, p1_rvalid, ~prev_g1, prev_g1); end
                n_checks++; if (prev_g1 ? (p1_rdata !== 32'h0000_00BE) : (p0_rdata !== 32'hDEAD_BEEF)) begin n_fail++; $display("FAIL %s_rdata[%0d]: got %h/%h want deadbeef/000000be", tag, i, p0_rdata, p1_rdata); end
            end
            prev_g1 = g1;
            @(negedge clk_i);
        end
        idle();
    endtask

    task automatic test_misalign();
        set_p1(1'b1, 1'b1, 2'b00, 32'h20, 32'hCAFE_F00D);
        @(negedge clk_i);
        set_p1(1'b1, 1'b1, 2'b00, 32'h22, 32'h1234_5678); #1;
        n_checks++; if (p1_gnt !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL mis_wr_block: got gnt=%b we=%b want 1 0", p1_gnt, mem_we); end
        @(posedge clk_i); #1;
        n_checks++; if (p1_rvalid !== 1'b1 || p1_err !== 1'b1 || p1_rdata !== 32'h0) begin n_fail++; $display("FAIL mis_wr_rsp: got rv=%b err=%b d=%h want 1 1 0", p1_rvalid, p1_err, p1_rdata); end
        @(negedge clk_i);
        set_p1(1'b1, 1'b0, 2'b00, 32'h20, 32'h0);
        @(posedge clk_i); #1;
        n_checks++; if (p1_rdata !== 32'hCAFE_F00D || p1_err !== 1'b0) begin n_fail++; $display("FAIL mis_unchanged: got d=%h err=%b want cafef00d 0", p1_rdata, p1_err); end
        @(negedge clk_i);
        idle();
    endtask

    task automatic test_widths();
        logic [7:0] bv;
        for (int k = 0; k < 4; k++) begin
            bv = 8'(8'h11 * (k + 1));
            set_p1(1'b1, 1'b1, 2'b01, 32'h40 + 32'(k), {24'h0, bv});
            @(negedge clk_i);
        end
        idle();
        set_p0(1'b1, 1'b0, 2'b10, 32'h42, 32'h0);
        @(posedge clk_i); #1;
        n_checks++; if (p0_rdata[15:0] !== 16'h4433 || p0_err !== 1'b0) begin n_fail++; $display("FAIL hw_read: got %h err=%b want 4433 0", p0_rdata[15:0], p0_err); end
        @(negedge clk_i);
        set_p0(1'b1, 1'b0, 2'b10, 32'h41, 32'h0);
        @(posedge clk_i); #1;
        n_checks++; if (p0_err !== 1'b1 || p0_rdata !== 32'h0) begin n_fail++; $display("FAIL hw_misalign: got err=%b d=%h want 1 0", p0_err, p0_rdata); end
        @(negedge clk_i);
        set_p0(1'b1, 1'b0, 2'b11, 32'h40, 32'h0);
        @(posedge clk_i); #1;
        n_checks++; if (p0_rdata !== 32'h4433_2211 || p0_err !== 1'b0) begin n_fail++; $display("FAIL w11_word: got %h err=%b want 44332211 0", p0_rdata, p0_err); end
        @(negedge clk_i);
        set_p0(1'b1, 1'b0, 2'b11, 32'h41, 32'h0);
        @(posedge clk_i); #1;
        n_checks++; if (p0_err !== 1'b1) begin n_fail++; $display("FAIL w11_misalign: got %b want 1", p0_err); end
        @(negedge clk_i);
        set_p0(1'b1, 1'b0, 2'b01, 32'h43, 32'h0);
        @(posedge clk_i); #1;
        n_checks++; if (p0_rdata !== 32'h44 || p0_err !== 1'b0) begin n_fail++; $display("FAIL byte_odd: got %h err=%b want 00000044 0", p0_rdata, p0_err); end
        @(negedge clk_i);
        idle();
    endtask

    task automatic test_reset_mid();
        // Three contended cycles bring the starve counter to 3.
        set_p0(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
        set_p1(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
        repeat (3) @(negedge clk_i);
        #1;
        n_checks++; if (p0_gnt !== 1'b1) begin n_fail++; $display("FAIL rm_pre_gnt: got %b want 1", p0_gnt); end
        #2 reset_i = 1'b1; #1;
        n_checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0 || p0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rm_forced: got g=%b%b rv=%b want 00 0", p0_gnt, p1_gnt, p0_rvalid); end
        @(posedge clk_i); #1;
        n_checks++; if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rm_no_rsp: got %b%b want 00", p0_rvalid, p1_rvalid); end
        @(negedge clk_i);
        reset_i = 1'b0; #1;
        // Cleared counter means port 0 still wins the first contended cycle.
        n_checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin n_fail++; $display("FAIL rm_counter_clear: got %b%b want 10", p0_gnt, p1_gnt); end
        @(negedge clk_i);
        idle();
        set_p1(1'b1, 1'b0, 2'b00, 32'h20, 32'h0); #1;
        n_checks++; if (p1_gnt !== 1'b1) begin n_fail++; $display("FAIL rm_p1_gnt: got %b want 1", p1_gnt); end
        @(posedge clk_i); #1;
        n_checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rm_p1_rsp: got rv=%b d=%h want 1 cafef00d", p1_rvalid, p1_rdata); end
        @(negedge clk_i);
        idle();
    endtask

    task automatic test_withdrawn();
        set_p0(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
        set_p1(1'b1, 1'b0, 2'b00, 32'h20, 32'h0); #1;
        n_checks++; if (p1_gnt !== 1'b0 || p0_gnt !== 1'b1) begin n_fail++; $display("FAIL wd_pulse_gnt: got %b%b want 10", p0_gnt, p1_gnt); end
        @(negedge clk_i);
        p1_req = 1'b0; #1;
        n_checks++; if (p1_gnt !== 1'b0 || p1_rvalid !== 1'b0) begin n_fail++; $display("FAIL wd_no_rsp1: got g=%b rv=%b want 0 0", p1_gnt, p1_rvalid); end
        @(negedge clk_i);
        idle(); #1;
        n_checks++; if (p1_rvalid !== 1'b0) begin n_fail++; $display("FAIL wd_no_rsp2: got %b want 0", p1_rvalid); end
        @(negedge clk_i);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        idle();
        test_reset();
        @(negedge clk_i);
        test_solo();
        test_contention(10, "cont");
        @(negedge clk_i);
        test_misalign();
        test_widths();
        test_reset_mid();
        test_withdrawn();
        // Counter back at zero: full P0 x4, P1 sequence again.
        test_contention(5, "wd_cont");
        @(negedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
